// File: rtl/mem_stage_pkg.sv
// Shared defines for the MEM pipeline stage: bus widths, stall encoding and bus layouts.
// Optional feature macro used by mem_stage: MEM_ALIGN_CHECK_EN.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 84;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;

  typedef logic [5:0] StallBus;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // Bit positions inside mem_op; at most one is set.
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  typedef struct packed {
    logic [7:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_wr_t;

  typedef struct packed {
    logic [31:0] pc;
    rf_wr_t      wr;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: selects byte/halfword/word from the SRAM read
// word by byte offset and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'h0;
    if (mem_op[OP_LB])       load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (mem_op[OP_LBU]) load_data = {24'h0, byte_sel};
    else if (mem_op[OP_LH])  load_data = {{16{half_sel[15]}}, half_sel};
    else if (mem_op[OP_LHU]) load_data = {16'h0, half_sel};
    else if (mem_op[OP_LW])  load_data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load alignment, writeback and forwarding buses.
// Optional misaligned-load detection enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  StallBus                  stall,
  input  logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
  input  logic [31:0]              data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0]  mem_to_rf_bus,
  output logic                     addr_misalign
);

  ex_mem_t     pipe_d, pipe_q;
  logic [31:0] load_data;
  rf_wr_t      wr;
  mem_wb_t     wb;
  logic        unused_bits;

  // Reset beats bubble, bubble beats capture; a stalled MEM stage holds.
  always_comb begin
    pipe_d = pipe_q;
    if (rst)
      pipe_d = '0;
    else if (stall[STALL_EX] == Stop && stall[STALL_MEM] == NoStop)
      pipe_d = '0;
    else if (stall[STALL_EX] == NoStop)
      pipe_d = ex_mem_t'(ex_to_mem_bus);
  end

  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  mem_load_align u_load_align (
    .mem_op    (pipe_q.mem_op),
    .offset    (pipe_q.ex_result[1:0]),
    .rdata     (data_sram_rdata),
    .load_data (load_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    addr_misalign = ((pipe_q.mem_op[OP_LH] | pipe_q.mem_op[OP_LHU]) & pipe_q.ex_result[0])
                  | (pipe_q.mem_op[OP_LW] & (pipe_q.ex_result[1:0] != 2'b00));
  end
`else
  assign addr_misalign = 1'b0;
`endif

  always_comb begin
    wr.rf_we    = pipe_q.rf_we & ~addr_misalign;
    wr.rf_waddr = pipe_q.rf_waddr;
    wr.rf_wdata = pipe_q.sel_rf_res ? load_data : pipe_q.ex_result;
    wb.pc       = pipe_q.pc;
    wb.wr       = wr;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_rf_bus = wr;

  // Store strobes are consumed by EX when it issues the SRAM request.
  assign unused_bits = ^{pipe_q.data_ram_en, pipe_q.data_ram_wen,
                         pipe_q.mem_op[OP_SB], pipe_q.mem_op[OP_SH], pipe_q.mem_op[OP_SW]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage; expected writeback words are queued when a
// step is driven and compared once the stage presents them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  StallBus     stall;
  logic [83:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        addr_misalign;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [69:0] wb;
    logic        mis;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .addr_misalign   (addr_misalign)
  );

  function automatic logic [83:0] mk_bus(logic [7:0] op, logic [31:0] pc, logic sel,
                                         logic we, logic [4:0] wa, logic [31:0] res);
    logic [3:0] wen;
    wen = op[OP_SW] ? 4'hF : (op[OP_SH] ? 4'h3 : (op[OP_SB] ? 4'h1 : 4'h0));
    return {op, pc, |op, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] mk_wb(logic [31:0] pc, logic we, logic [4:0] wa,
                                        logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  task automatic chk(string tag, logic [69:0] obs, logic [69:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive EX-side inputs, capture, present SRAM word, then compare at negedge.
  task automatic step(string tag, logic r, StallBus st, logic [83:0] bus, logic [31:0] rd,
                      logic [69:0] exp_wb, logic exp_mis);
    exp_t e;
    rst = r;
    stall = st;
    ex_to_mem_bus = bus;
    e.tag = tag; e.wb = exp_wb; e.mis = exp_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    data_sram_rdata = rd;
    ex_to_mem_bus = $urandom();
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".wb"}, mem_to_wb_bus, e.wb);
      chk({e.tag, ".rf"}, {32'h0, mem_to_rf_bus}, {32'h0, e.wb[37:0]});
      chk({e.tag, ".mis"}, {69'h0, addr_misalign}, {69'h0, e.mis});
    end
    $display("step %-10s wb=%h rf=%h mis=%b", tag, mem_to_wb_bus, mem_to_rf_bus, addr_misalign);
  endtask

  localparam logic [7:0] LB  = 8'h80, LBU = 8'h40, LH = 8'h20, LHU = 8'h10,
                         LW  = 8'h08, SW  = 8'h01;
  localparam StallBus RUN = 6'b000000, BUBBLE = 6'b001000, HOLD = 6'b011000;

  initial begin
    rst = 1'b1;
    stall = RUN;
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'h0;
    @(negedge clk);

    step("reset", 1'b1, RUN, mk_bus(LW, 32'h44, 1'b1, 1'b1, 5'd9, 32'h10), 32'hFFFFFFFF,
         mk_wb(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);
    step("lw", 1'b0, RUN, mk_bus(LW, 32'h100, 1'b1, 1'b1, 5'd5, 32'h1000), 32'h89ABCDEF,
         mk_wb(32'h100, 1'b1, 5'd5, 32'h89ABCDEF), 1'b0);
    step("lb", 1'b0, RUN, mk_bus(LB, 32'h104, 1'b1, 1'b1, 5'd6, 32'h1003), 32'h80FF0011,
         mk_wb(32'h104, 1'b1, 5'd6, 32'hFFFFFF80), 1'b0);
    step("lbu", 1'b0, RUN, mk_bus(LBU, 32'h108, 1'b1, 1'b1, 5'd7, 32'h1003), 32'h80FF0011,
         mk_wb(32'h108, 1'b1, 5'd7, 32'h00000080), 1'b0);
    step("lbu_off1", 1'b0, RUN, mk_bus(LBU, 32'h10C, 1'b1, 1'b1, 5'd7, 32'h1001), 32'h80FF0011,
         mk_wb(32'h10C, 1'b1, 5'd7, 32'h00000000), 1'b0);
    step("lh", 1'b0, RUN, mk_bus(LH, 32'h110, 1'b1, 1'b1, 5'd8, 32'h2002), 32'h80017FFF,
         mk_wb(32'h110, 1'b1, 5'd8, 32'hFFFF8001), 1'b0);
    step("lhu", 1'b0, RUN, mk_bus(LHU, 32'h114, 1'b1, 1'b1, 5'd9, 32'h2002), 32'h80017FFF,
         mk_wb(32'h114, 1'b1, 5'd9, 32'h00008001), 1'b0);
    step("lh_off0", 1'b0, RUN, mk_bus(LH, 32'h118, 1'b1, 1'b1, 5'd10, 32'h2000), 32'h80017FFF,
         mk_wb(32'h118, 1'b1, 5'd10, 32'h00007FFF), 1'b0);
    step("alu", 1'b0, RUN, mk_bus(8'h00, 32'h11C, 1'b0, 1'b1, 5'd11, 32'h12345678), 32'hDEADBEEF,
         mk_wb(32'h11C, 1'b1, 5'd11, 32'h12345678), 1'b0);
    step("hold", 1'b0, HOLD, mk_bus(LW, 32'h999, 1'b1, 1'b1, 5'd31, 32'hAAAA0000), 32'h0BADF00D,
         mk_wb(32'h11C, 1'b1, 5'd11, 32'h12345678), 1'b0);
    step("bubble", 1'b0, BUBBLE, mk_bus(LW, 32'h120, 1'b1, 1'b1, 5'd12, 32'h3000), 32'hCAFEBABE,
         mk_wb(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);
    step("sw", 1'b0, RUN, mk_bus(SW, 32'h124, 1'b0, 1'b0, 5'd0, 32'h4008), 32'h55555555,
         mk_wb(32'h124, 1'b0, 5'd0, 32'h4008), 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    step("lw_mis", 1'b0, RUN, mk_bus(LW, 32'h128, 1'b1, 1'b1, 5'd13, 32'h5002), 32'h13579BDF,
         mk_wb(32'h128, 1'b0, 5'd13, 32'h13579BDF), 1'b1);
    step("lh_mis", 1'b0, RUN, mk_bus(LH, 32'h12C, 1'b1, 1'b1, 5'd14, 32'h5001), 32'h80017FFF,
         mk_wb(32'h12C, 1'b0, 5'd14, 32'h00007FFF), 1'b1);
`else
    step("lw_off2", 1'b0, RUN, mk_bus(LW, 32'h128, 1'b1, 1'b1, 5'd13, 32'h5002), 32'h13579BDF,
         mk_wb(32'h128, 1'b1, 5'd13, 32'h13579BDF), 1'b0);
`endif
    step("alu2", 1'b0, RUN, mk_bus(8'h00, 32'h130, 1'b0, 1'b1, 5'd15, 32'h0F0F0F0F), 32'hFFFFFFFF,
         mk_wb(32'h130, 1'b1, 5'd15, 32'h0F0F0F0F), 1'b0);
    step("rst_stall", 1'b1, HOLD, mk_bus(LW, 32'h134, 1'b1, 1'b1, 5'd16, 32'h6000), 32'hFFFFFFFF,
         mk_wb(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);
    step("post_rst", 1'b0, HOLD, mk_bus(LW, 32'h138, 1'b1, 1'b1, 5'd17, 32'h7000), 32'hFFFFFFFF,
         mk_wb(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
